// File: rtl/alt_vipitc121_common_timing_measure.sv
// Video sync timing measurement: line length, frame length, field sequence and lock qualifiers.
// Define ALT_VIPITC_TIMING_MEASURE_UNLOCK_CNT_EN to add the unlock_count output.
module alt_vipitc121_common_timing_measure #(
  parameter int unsigned TOTALS_MINUS_ONE = 0,
  parameter int unsigned STABLE_FRAMES    = 3,
  parameter int unsigned SAMPLE_TOLERANCE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_enable,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        field,
  output logic        start_of_vsync,
  output logic        field_prediction,
  output logic        interlaced,
  output logic [13:0] total_sample_count,
  output logic        total_sample_count_valid,
  output logic [12:0] total_line_count,
  output logic        total_line_count_valid,
  output logic        stable
`ifdef ALT_VIPITC_TIMING_MEASURE_UNLOCK_CNT_EN
  ,
  output logic [7:0]  unlock_count
`endif
);

  localparam logic [13:0] HMax    = '1;
  localparam logic [12:0] VMax    = '1;
  localparam logic [13:0] TmoH    = 14'(TOTALS_MINUS_ONE);
  localparam logic [12:0] TmoV    = 13'(TOTALS_MINUS_ONE);
  localparam logic [14:0] Tol     = 15'(SAMPLE_TOLERANCE);
  localparam logic [3:0]  LockMax = 4'(STABLE_FRAMES);

  logic        hs_d_q, hs_d_d, vs_d_q, vs_d_d;
  logic [13:0] h_cnt_q, h_cnt_d, h_prev_q, h_prev_d, scnt_q, scnt_d;
  logic        h_seed_q, h_seed_d, svalid_q, svalid_d;
  logic [12:0] v_cnt_q, v_cnt_d, v_prev_q, v_prev_d, lcnt_q, lcnt_d;
  logic        lvalid_q, lvalid_d;
  logic        f_last_q, f_last_d, interlaced_q, interlaced_d;
  logic        sov_q, sov_d, fpred_q, fpred_d;
  logic [3:0]  lock_q, lock_d;

  logic        hs_edge, vs_edge, h_ovf, v_ovf, s_match, n_match;
  logic [13:0] m_val;
  logic [12:0] n_val;
  logic [14:0] s_diff, s_abs;

  assign hs_edge = sample_enable & hsync & ~hs_d_q;
  assign vs_edge = sample_enable & vsync & ~vs_d_q;
  // A saturated counter at the delimiting edge means the interval overflowed.
  assign h_ovf   = (h_cnt_q == HMax);
  assign v_ovf   = (v_cnt_q == VMax);
  assign m_val   = h_cnt_q - TmoH;
  assign n_val   = v_cnt_q - TmoV;
  assign s_diff  = {1'b0, m_val} - {1'b0, h_prev_q};
  assign s_abs   = s_diff[14] ? (15'd0 - s_diff) : s_diff;
  assign s_match = (s_abs <= Tol);
  assign n_match = (n_val == v_prev_q) && !v_ovf;

  always_comb begin
    hs_d_d       = hs_d_q;
    vs_d_d       = vs_d_q;
    h_cnt_d      = h_cnt_q;
    h_prev_d     = h_prev_q;
    h_seed_d     = h_seed_q;
    scnt_d       = scnt_q;
    svalid_d     = svalid_q;
    v_cnt_d      = v_cnt_q;
    v_prev_d     = v_prev_q;
    lcnt_d       = lcnt_q;
    lvalid_d     = lvalid_q;
    f_last_d     = f_last_q;
    interlaced_d = interlaced_q;
    fpred_d      = fpred_q;
    lock_d       = lock_q;
    sov_d        = vs_edge;

    if (sample_enable) begin
      hs_d_d = hsync;
      vs_d_d = vsync;
    end

    if (hs_edge) begin
      h_cnt_d  = 14'd1;
      h_prev_d = m_val;
      h_seed_d = 1'b1;
      if (h_seed_q && s_match && !h_ovf) begin
        scnt_d   = m_val;
        svalid_d = 1'b1;
      end else begin
        svalid_d = 1'b0;
      end
      if (!v_ovf) v_cnt_d = v_cnt_q + 13'd1;
    end else if (sample_enable && !h_ovf) begin
      h_cnt_d = h_cnt_q + 14'd1;
    end

    if (vs_edge) begin
      f_last_d     = field;
      interlaced_d = (field != f_last_q);
      fpred_d      = interlaced_q & ~f_last_q;
      if (!field) begin
        // A coincident hsync edge is line 1 of the new frame.
        v_cnt_d  = {12'd0, hs_edge};
        v_prev_d = n_val;
        if (n_match) begin
          lcnt_d   = n_val;
          lvalid_d = 1'b1;
        end else begin
          lvalid_d = 1'b0;
        end
        if (svalid_q && n_match) begin
          lock_d = (lock_q >= LockMax) ? lock_q : lock_q + 4'd1;
        end else begin
          lock_d = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_d_q       <= 1'b0;
      vs_d_q       <= 1'b0;
      h_cnt_q      <= '0;
      h_prev_q     <= '0;
      h_seed_q     <= 1'b0;
      scnt_q       <= '0;
      svalid_q     <= 1'b0;
      v_cnt_q      <= '0;
      v_prev_q     <= '0;
      lcnt_q       <= '0;
      lvalid_q     <= 1'b0;
      f_last_q     <= 1'b0;
      interlaced_q <= 1'b0;
      sov_q        <= 1'b0;
      fpred_q      <= 1'b0;
      lock_q       <= '0;
    end else begin
      hs_d_q       <= hs_d_d;
      vs_d_q       <= vs_d_d;
      h_cnt_q      <= h_cnt_d;
      h_prev_q     <= h_prev_d;
      h_seed_q     <= h_seed_d;
      scnt_q       <= scnt_d;
      svalid_q     <= svalid_d;
      v_cnt_q      <= v_cnt_d;
      v_prev_q     <= v_prev_d;
      lcnt_q       <= lcnt_d;
      lvalid_q     <= lvalid_d;
      f_last_q     <= f_last_d;
      interlaced_q <= interlaced_d;
      sov_q        <= sov_d;
      fpred_q      <= fpred_d;
      lock_q       <= lock_d;
    end
  end

  assign start_of_vsync           = sov_q;
  assign field_prediction         = fpred_q;
  assign interlaced               = interlaced_q;
  assign total_sample_count       = scnt_q;
  assign total_sample_count_valid = svalid_q;
  assign total_line_count         = lcnt_q;
  assign total_line_count_valid   = lvalid_q;
  // Combinational from registered state so a lost valid drops stable immediately.
  assign stable = (lock_q == LockMax) & svalid_q & lvalid_q;

`ifdef ALT_VIPITC_TIMING_MEASURE_UNLOCK_CNT_EN
  logic       stable_prev_q;
  logic [7:0] unlock_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_prev_q <= 1'b0;
      unlock_q      <= '0;
    end else begin
      stable_prev_q <= stable;
      if (stable_prev_q && !stable && unlock_q != 8'hff) unlock_q <= unlock_q + 8'd1;
    end
  end

  assign unlock_count = unlock_q;
`endif

endmodule

// File: tb/tb_alt_vipitc121_common_timing_measure.sv
// Directed bench: table of progressive formats, then interlace, tolerance, overflow and reset.
module tb_alt_vipitc121_common_timing_measure;

  logic clk = 1'b0;
  logic rst, sample_enable, hsync, vsync, field;
  always #5 clk = ~clk;

  logic        sov0, fp0, il0, scv0, lcv0, st0;
  logic [13:0] sc0;
  logic [12:0] lc0;
  logic        sov1, fp1, il1, scv1, lcv1, st1;
  logic [13:0] sc1;
  logic [12:0] lc1;
  logic        sov3, fp3, il3, scv3, lcv3, st3;
  logic [13:0] sc3;
  logic [12:0] lc3;

  alt_vipitc121_common_timing_measure #(
    .TOTALS_MINUS_ONE(0), .STABLE_FRAMES(3), .SAMPLE_TOLERANCE(2)
  ) dut (
    .clk(clk), .rst(rst), .sample_enable(sample_enable), .hsync(hsync), .vsync(vsync),
    .field(field), .start_of_vsync(sov0), .field_prediction(fp0), .interlaced(il0),
    .total_sample_count(sc0), .total_sample_count_valid(scv0), .total_line_count(lc0),
    .total_line_count_valid(lcv0), .stable(st0)
  );

  alt_vipitc121_common_timing_measure #(
    .TOTALS_MINUS_ONE(1), .STABLE_FRAMES(3), .SAMPLE_TOLERANCE(0)
  ) dut_m1 (
    .clk(clk), .rst(rst), .sample_enable(sample_enable), .hsync(hsync), .vsync(vsync),
    .field(field), .start_of_vsync(sov1), .field_prediction(fp1), .interlaced(il1),
    .total_sample_count(sc1), .total_sample_count_valid(scv1), .total_line_count(lc1),
    .total_line_count_valid(lcv1), .stable(st1)
  );

  alt_vipitc121_common_timing_measure #(
    .TOTALS_MINUS_ONE(0), .STABLE_FRAMES(3), .SAMPLE_TOLERANCE(3)
  ) dut_t3 (
    .clk(clk), .rst(rst), .sample_enable(sample_enable), .hsync(hsync), .vsync(vsync),
    .field(field), .start_of_vsync(sov3), .field_prediction(fp3), .interlaced(il3),
    .total_sample_count(sc3), .total_sample_count_valid(scv3), .total_line_count(lc3),
    .total_line_count_valid(lcv3), .stable(st3)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit toggle_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One video sample; in toggle mode each enabled cycle is followed by a disabled one.
  task automatic cyc(input logic hs, input logic vs, input logic f);
    sample_enable = 1'b1; hsync = hs; vsync = vs; field = f;
    @(posedge clk); #1;
    if (toggle_en) begin
      sample_enable = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_line(input int len, input bit vs, input bit f);
    for (int i = 0; i < len; i++) cyc(i == 0, vs && (i == 0), f);
  endtask

  task automatic send_frame(input int len, input int lines, input bit vs, input bit f);
    for (int l = 0; l < lines; l++) send_line(len, vs && (l == 0), f);
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_enable = 1'b0; hsync = 1'b0; vsync = 1'b0; field = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // start_of_vsync monitor: captured predictions and any pulse longer than one clk
  bit fp_q[$];
  int sov_long = 0;
  logic sov_prev = 1'b0;
  always @(negedge clk) begin
    if (sov0) fp_q.push_back(fp0);
    if (sov0 && sov_prev) sov_long++;
    sov_prev = sov0;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  typedef struct {
    int len;
    int lines;
    bit tog;
    int sc0;
    int lc0;
    int sc1;
    int lc1;
  } vec_t;

  vec_t vecs[4];
  bit   fp_exp[6];

  initial begin
    vecs[0] = '{len: 100, lines: 10, tog: 1'b0, sc0: 100, lc0: 10, sc1: 99, lc1: 9};
    vecs[1] = '{len: 100, lines: 10, tog: 1'b1, sc0: 100, lc0: 10, sc1: 99, lc1: 9};
    vecs[2] = '{len: 37,  lines: 6,  tog: 1'b0, sc0: 37,  lc0: 6,  sc1: 36, lc1: 5};
    vecs[3] = '{len: 64,  lines: 3,  tog: 1'b1, sc0: 64,  lc0: 3,  sc1: 63, lc1: 2};
    fp_exp  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    do_reset();
    chk("rst_sample_count", sc0, 0);
    chk("rst_sample_valid", scv0, 0);
    chk("rst_line_count", lc0, 0);
    chk("rst_line_valid", lcv0, 0);
    chk("rst_stable", st0, 0);
    chk("rst_interlaced", il0, 0);
    chk("rst_field_pred", fp0, 0);
    chk("rst_sov", sov0, 0);

    // Lead-in frame without vsync, then four frames each opening with an F0 vsync.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      toggle_en = vecs[v].tog;
      send_frame(vecs[v].len, vecs[v].lines, 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
        send_frame(vecs[v].len, vecs[v].lines, 1'b1, 1'b0);
        chk($sformatf("v%0d_f%0d_stable", v, k), st0, int'(k >= 4));
        chk($sformatf("v%0d_f%0d_stable_m1", v, k), st1, int'(k >= 4));
        chk($sformatf("v%0d_f%0d_line_valid", v, k), lcv0, int'(k >= 2));
      end
      chk($sformatf("v%0d_sample_count", v), sc0, vecs[v].sc0);
      chk($sformatf("v%0d_sample_valid", v), scv0, 1);
      chk($sformatf("v%0d_line_count", v), lc0, vecs[v].lc0);
      chk($sformatf("v%0d_sample_count_m1", v), sc1, vecs[v].sc1);
      chk($sformatf("v%0d_line_count_m1", v), lc1, vecs[v].lc1);
      chk($sformatf("v%0d_interlaced", v), il0, 0);
      chk($sformatf("v%0d_field_pred", v), fp0, 0);
    end
    toggle_en = 1'b0;

    // Interlaced: F0 field of 263 lines, F1 field of 262 lines, three frames.
    do_reset();
    fp_q.delete();
    send_frame(8, 10, 1'b0, 1'b0);
    for (int fr = 0; fr < 3; fr++) begin
      send_frame(8, 263, 1'b1, 1'b0);
      send_frame(8, 262, 1'b1, 1'b1);
    end
    chk("il_interlaced", il0, 1);
    chk("il_line_count", lc0, 525);
    chk("il_line_valid", lcv0, 1);
    chk("il_line_count_m1", lc1, 524);
    chk("il_sample_count", sc0, 8);
    chk("il_stable", st0, 0);
    chk("il_sov_pulses", fp_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < fp_q.size()) chk($sformatf("il_pred%0d", i), fp_q[i], fp_exp[i]);
      else chk($sformatf("il_pred%0d_missing", i), 0, 1);
    end
    chk("sov_single_cycle", sov_long, 0);

    // Lock, then a 103-sample line: tolerance 2 loses lock, tolerance 3 keeps it.
    do_reset();
    send_frame(100, 10, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_frame(100, 10, 1'b1, 1'b0);
    chk("tol_locked_t2", st0, 1);
    chk("tol_locked_t3", st3, 1);
    send_line(103, 1'b0, 1'b0);
    chk("tol_valid_before_edge", scv0, 1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("tol2_sample_valid", scv0, 0);
    chk("tol2_stable", st0, 0);
    chk("tol2_count_held", sc0, 100);
    chk("tol0_sample_valid", scv1, 0);
    chk("tol3_sample_valid", scv3, 1);
    chk("tol3_count", sc3, 103);
    chk("tol3_stable", st3, 1);

    // hsync low for 20000 samples saturates the line counter.
    for (int i = 0; i < 20000; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("ovf_valid_before_edge", scv3, 1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("ovf_sample_valid", scv3, 0);
    chk("ovf_stable", st3, 0);
    chk("ovf_count_held", sc3, 103);

    // Reset mid-line clears everything, then relock from scratch.
    for (int i = 1; i < 50; i++) cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_sample_count", sc3, 0);
    chk("mrst_sample_valid", scv3, 0);
    chk("mrst_line_count", lc3, 0);
    chk("mrst_line_valid", lcv3, 0);
    chk("mrst_stable", st3, 0);
    rst = 1'b0;
    send_frame(20, 4, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_frame(20, 4, 1'b1, 1'b0);
    chk("relock_stable", st3, 1);
    chk("relock_sample_count", sc3, 20);
    chk("relock_line_count", lc3, 4);
    chk("relock_stable_t2", st0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
